// File: rtl/ahb_ctrl_pkg.sv
// Shared types and constants for the two-master AHB-lite bus controller.
// Master ids double as mux select values and as indices into request/grant vectors.
package ahb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef logic master_t;

  localparam master_t MASTER_1 = 1'b0;
  localparam master_t MASTER_2 = 1'b1;

  function automatic logic [1:0] master_onehot(input master_t m);
    return (m == MASTER_2) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: ptr_i names the preferred master when both request.
// Purely combinational; output is one-hot or zero.
module rr_arbiter_2
  import ahb_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  master_t    ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (ptr_i == MASTER_1 || !req_i[1])) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/ahb_bus_controller.sv
// Two-master AHB-lite sequencer: round-robin arbitration, address/data phase load enables
// and mux selects, with slave wait-state and error handling. All outputs are registered.
module ahb_bus_controller
  import ahb_ctrl_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hbusreq_1,
  input  logic       hbusreq_2,
  input  logic       hreadyout,
  input  logic       hresponse,
  output logic       hgrant_1,
  output logic       hgrant_2,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       sel4,
  output logic       mux1,
  output logic       mux2,
  output logic [1:0] htrans,
  output logic       hmaster
);

  state_e           state_q, state_d;
  logic             addr_issued_q, addr_issued_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  master_t          ptr_q, ptr_d;
  master_t          owner_q, owner_d;
  master_t          data_owner_q, data_owner_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       sel_addr_q, sel_addr_d;
  logic [1:0]       sel_data_q, sel_data_d;
  logic [1:0]       htrans_q, htrans_d;

  logic [1:0] req;
  logic [1:0] pick;
  master_t    other_m;
  logic       owner_req;
  logic       other_req;
  logic       burst_more;

  assign req        = {hbusreq_2, hbusreq_1};
  assign other_m    = ~owner_q;
  assign owner_req  = req[owner_q];
  assign other_req  = req[other_m];
  assign burst_more = (beat_cnt_q < CNT_W'(BURST_MAX));

  rr_arbiter_2 u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  // ADDR is entered with addr_issued=0 right after a grant (load pulse still to come),
  // or with addr_issued=1 when a burst continues and the pulse was issued on the same edge.
  always_comb begin
    state_d       = state_q;
    addr_issued_d = addr_issued_q;
    beat_cnt_d    = beat_cnt_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    data_owner_d  = data_owner_q;
    grant_d       = grant_q;
    htrans_d      = htrans_q;
    sel_addr_d    = 2'b00;
    sel_data_d    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        htrans_d = HTRANS_IDLE;
        if (|req) begin
          owner_d       = pick[1] ? MASTER_2 : MASTER_1;
          grant_d       = pick;
          addr_issued_d = 1'b0;
          state_d       = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!addr_issued_q) begin
          sel_addr_d    = master_onehot(owner_q);
          htrans_d      = (beat_cnt_q == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
          addr_issued_d = 1'b1;
        end else begin
          sel_data_d   = master_onehot(owner_q);
          data_owner_d = owner_q;
          beat_cnt_d   = beat_cnt_q + CNT_W'(1);
          htrans_d     = HTRANS_IDLE;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        if (hreadyout) begin
          if (owner_req && burst_more) begin
            sel_addr_d    = master_onehot(owner_q);
            htrans_d      = HTRANS_SEQ;
            addr_issued_d = 1'b1;
            state_d       = ST_ADDR;
          end else begin
            beat_cnt_d = '0;
            ptr_d      = other_m;
            if (other_req) begin
              owner_d       = other_m;
              grant_d       = master_onehot(other_m);
              addr_issued_d = 1'b0;
              state_d       = ST_ADDR;
            end else begin
              grant_d = 2'b00;
              state_d = ST_IDLE;
            end
          end
        end else if (hresponse) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        htrans_d = HTRANS_IDLE;
        if (hreadyout) begin
          grant_d    = 2'b00;
          beat_cnt_d = '0;
          ptr_d      = other_m;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_issued_q <= 1'b0;
      beat_cnt_q    <= '0;
      ptr_q         <= MASTER_1;
      owner_q       <= MASTER_1;
      data_owner_q  <= MASTER_1;
      grant_q       <= 2'b00;
      sel_addr_q    <= 2'b00;
      sel_data_q    <= 2'b00;
      htrans_q      <= HTRANS_IDLE;
    end else begin
      state_q       <= state_d;
      addr_issued_q <= addr_issued_d;
      beat_cnt_q    <= beat_cnt_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      data_owner_q  <= data_owner_d;
      grant_q       <= grant_d;
      sel_addr_q    <= sel_addr_d;
      sel_data_q    <= sel_data_d;
      htrans_q      <= htrans_d;
    end
  end

  assign hgrant_1 = grant_q[0];
  assign hgrant_2 = grant_q[1];
  assign sel1     = sel_addr_q[0];
  assign sel2     = sel_addr_q[1];
  assign sel3     = sel_data_q[0];
  assign sel4     = sel_data_q[1];
  assign mux1     = owner_q;
  assign hmaster  = owner_q;
  assign mux2     = data_owner_q;
  assign htrans   = htrans_q;

endmodule

// File: tb/tb_ahb_bus_controller.sv
// Scoreboarded bench: a transaction-level arbitration model predicts the beat order per scenario,
// bench-side master/slave agents drive requests and wait states, a monitor pops and compares.
module tb_ahb_bus_controller;

  localparam int BURST_MAX = 4;
  localparam int CNT_W     = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       hbusreq_1, hbusreq_2, hreadyout, hresponse;
  logic       hgrant_1, hgrant_2, sel1, sel2, sel3, sel4, mux1, mux2, hmaster;
  logic [1:0] htrans;

  ahb_bus_controller #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .hbusreq_1 (hbusreq_1),
    .hbusreq_2 (hbusreq_2),
    .hreadyout (hreadyout),
    .hresponse (hresponse),
    .hgrant_1  (hgrant_1),
    .hgrant_2  (hgrant_2),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel3      (sel3),
    .sel4      (sel4),
    .mux1      (mux1),
    .mux2      (mux2),
    .htrans    (htrans),
    .hmaster   (hmaster)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         m;
    logic [1:0] ht;
  } beat_t;

  beat_t exp_q[$];
  int    pend_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  int wanted[2];
  int issued[2];
  int m_ptr     = 0;
  int err_idx   = -1;
  int phase_idx = 0;
  int err_stage = 0;
  int waits     = 0;
  int min_wait  = 0;
  int max_wait  = 3;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Master agents request until all wanted address phases were seen; slave agent adds waits/errors.
  task automatic step();
    @(negedge clk);
    if (sel1) issued[0]++;
    if (sel2) issued[1]++;
    hbusreq_1 = (issued[0] < wanted[0]);
    hbusreq_2 = (issued[1] < wanted[1]);
    if (sel3 || sel4) begin
      if (phase_idx == err_idx) err_stage = 2;
      else waits = $urandom_range(max_wait, min_wait);
      phase_idx++;
    end
    if (err_stage == 2) begin
      hreadyout = 1'b0; hresponse = 1'b1; err_stage = 1;
    end else if (err_stage == 1) begin
      hreadyout = 1'b1; hresponse = 1'b1; err_stage = 0;
    end else if (waits > 0) begin
      hreadyout = 1'b0; hresponse = 1'b0; waits--;
    end else begin
      hreadyout = 1'b1; hresponse = 1'b0;
    end
  endtask

  // Reference: each tenure goes to the preferred master if it still wants beats, lasts up to
  // BURST_MAX beats or until an error beat, then preference passes to the other master.
  task automatic start_scn(input int n1, input int n2, input int err);
    int    rem[2];
    int    own;
    int    g;
    bit    stop;
    beat_t b;
    rem[0] = n1; rem[1] = n2; g = 0;
    while (rem[0] > 0 || rem[1] > 0) begin
      own  = (rem[m_ptr] > 0) ? m_ptr : 1 - m_ptr;
      stop = 1'b0;
      for (int k = 0; k < BURST_MAX && rem[own] > 0 && !stop; k++) begin
        b.m  = own;
        b.ht = (k == 0) ? 2'b10 : 2'b11;
        exp_q.push_back(b);
        rem[own]--;
        if (g == err) stop = 1'b1;
        g++;
      end
      m_ptr = 1 - own;
    end
    issued[0] = 0; issued[1] = 0;
    wanted[0] = n1; wanted[1] = n2;
    err_idx = err; phase_idx = 0;
    $display("scenario m1=%0d m2=%0d err_beat=%0d expected_beats=%0d", n1, n2, err, exp_q.size());
  endtask

  task automatic finish_scn();
    int cyc = 0;
    while (!(issued[0] == wanted[0] && issued[1] == wanted[1] && !hgrant_1 && !hgrant_2
             && err_stage == 0) && cyc < 3000) begin
      step();
      cyc++;
    end
    check("scn_complete", int'(cyc < 3000), 1);
    step();
    step();
    check("exp_drained", exp_q.size(), 0);
    exp_q.delete();
    pend_q.delete();
  endtask

  // Monitor / scoreboard
  initial begin
    beat_t e;
    int    m;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("exclusive", int'((hgrant_1 && hgrant_2) || (sel1 && sel2) || (sel3 && sel4)
              || ((sel1 || sel3) && !hgrant_1) || ((sel2 || sel4) && !hgrant_2)), 0);
        if (sel1 || sel2) begin
          m = sel2 ? 1 : 0;
          if (exp_q.size() == 0) begin
            check("addr_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("addr_master", m, e.m);
            check("addr_htrans", int'(htrans), int'(e.ht));
            check("addr_hmaster", int'(hmaster), e.m);
            check("addr_mux1", int'(mux1), e.m);
            $display("addr beat master=%0d htrans=%b expected master=%0d htrans=%b", m + 1, htrans, e.m + 1, e.ht);
          end
          pend_q.push_back(m);
        end
        if (sel3 || sel4) begin
          m = sel4 ? 1 : 0;
          if (pend_q.size() == 0) begin
            check("data_unexpected", 1, 0);
          end else begin
            check("data_master", m, pend_q.pop_front());
          end
          check("data_mux2", int'(mux2), m);
        end
      end
    end
  end

  initial begin
    int n1, n2, err, cyc, sel_cnt, mux_bad;
    rst = 1'b1; hbusreq_1 = 1'b0; hbusreq_2 = 1'b0; hreadyout = 1'b1; hresponse = 1'b0;
    wanted[0] = 0; wanted[1] = 0; issued[0] = 0; issued[1] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-burst: all outputs clear on the first reset edge and stay clear
    start_scn(6, 6, -1);
    repeat (8) step();
    rst = 1'b1;
    step();
    check("rst_outputs", int'({hgrant_1, hgrant_2, sel1, sel2, sel3, sel4, mux1, mux2, htrans, hmaster}), 0);
    step();
    check("rst_hold", int'({hgrant_1, hgrant_2, sel1, sel2, sel3, sel4, mux1, mux2, htrans, hmaster}), 0);
    rst = 1'b0;
    exp_q.delete(); pend_q.delete();
    wanted[0] = 0; wanted[1] = 0; issued[0] = 0; issued[1] = 0;
    err_stage = 0; waits = 0; m_ptr = 0;
    hbusreq_1 = 1'b0; hbusreq_2 = 1'b0; hreadyout = 1'b1; hresponse = 1'b0;
    step();
    mon_en = 1'b1;

    // Contention with full bursts: m1 first after reset
    start_scn(4, 4, -1);
    finish_scn();

    // Single m1 beat, exact cycle timing
    min_wait = 0; max_wait = 0;
    start_scn(1, 0, -1);
    step();
    step();
    check("t1_grant1", int'({hgrant_1, sel1}), 2);
    step();
    check("t2_sel1_htrans", int'({sel1, htrans}), 3'b110);
    step();
    check("t3_sel3_mux2", int'({sel3, mux2}), 2);
    step();
    check("t4_idle", int'({hgrant_1, htrans}), 0);
    finish_scn();

    // Three wait states on an m2 beat
    min_wait = 3; max_wait = 3;
    start_scn(0, 1, -1);
    cyc = 0;
    while (!sel4 && cyc < 20) begin step(); cyc++; end
    check("ws_entry_seen", int'(sel4), 1);
    cyc = 0; sel_cnt = 0; mux_bad = 0;
    while (hgrant_2 && cyc < 20) begin
      cyc++;
      sel_cnt += int'(sel4);
      if (mux2 != 1'b1) mux_bad++;
      step();
    end
    check("ws_phase_len", cyc, 4);
    check("ws_sel4_pulses", sel_cnt, 1);
    check("ws_mux2_stable", mux_bad, 0);
    finish_scn();

    // Error on first beat: tenure ends, m2 served next
    min_wait = 0; max_wait = 2;
    start_scn(2, 2, 0);
    finish_scn();

    // Early release: m2 stops after 2 of a possible 4 beats
    start_scn(0, 2, -1);
    finish_scn();
    check("early_release_grant", int'({hgrant_1, hgrant_2}), 0);

    // Single-beat requester against a long burst
    start_scn(1, 7, -1);
    finish_scn();

    for (int i = 0; i < 25; i++) begin
      n1 = $urandom_range(7, 0);
      n2 = $urandom_range(7, 0);
      err = -1;
      if ((n1 + n2) > 0 && $urandom_range(3, 0) == 0) err = $urandom_range(n1 + n2 - 1, 0);
      min_wait = 0;
      max_wait = $urandom_range(3, 0);
      start_scn(n1, n2, err);
      finish_scn();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
